totient_seg_checker: RTL and testbench

- Receive-side monitor for the Euler-totient seven-segment display stream.
- Each clk_0 cycle, samples the ABCDEFG segment lines, decodes them back to a hex digit, and locks onto the 16-value periodic sequence phi(1..16) = 1,1,2,2,4,2,6,4,6,4,10,4,12,6,8,8.
- Once locked, flags every deviation from the expected sequence, in ascending or descending order.
- Sits in the bench or on-chip self-test path, directly on the totient generator's segment outputs.

---
 rtl/totient_seg_checker.sv | 191 +++++++++++++++++++
 tb/tb_totient_seg_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/totient_seg_checker.sv
// totient_seg_checker
//   Receive-side monitor for the Euler-totient seven-segment stream. Decodes
//   the ABCDEFG lines back to a hex digit, locks onto the periodic sequence
//   phi(1..16) = 1,1,2,2,4,2,6,4,6,4,A,4,C,6,8,8 (ascending or descending)
//   and flags every deviation once locked.
//
//   Pipeline: stage 1 registers the decoded glyph, stage 2 (FSM) evaluates
//   it, so mismatch/period_done/locked trail the sampled edge by one more.
//
// Parameters
//   SEG_ACTIVE_LOW : 1 = lit segment is 0 (inputs inverted before decode)
//   ERR_W          : width of the saturating error counter
//
// Ports
//   clk_0          : clock, rising edge
//   R              : synchronous active-high reset
//   A..G           : segment lines, A is the MSB of the ABCDEFG pattern
//   dir            : 0 = ascending phi(1)->phi(16), 1 = descending
//   digit          : decoded value of the last legal sample (held on illegal)
//   digit_valid    : last sample was a legal glyph
//   seg_invalid    : 1-cycle pulse, last sample was an illegal glyph
//   locked         : FSM is in LOCKED
//   mismatch       : 1-cycle pulse, locked and sample differed / illegal
//   period_done    : 1-cycle pulse, last element of a period matched
//   err_cnt        : saturating count of mismatch pulses
//   fail_sticky    : set with the first mismatch, cleared only by R
//
// Optional feature macro: TOTIENT_CHK_STICKY_EN (builds the fail_sticky
// register; otherwise fail_sticky is tied to 0).
module totient_seg_checker #(
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter int ERR_W          = 8
) (
  input  logic             clk_0,
  input  logic             R,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  input  logic             E,
  input  logic             F,
  input  logic             G,
  input  logic             dir,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             seg_invalid,
  output logic             locked,
  output logic             mismatch,
  output logic             period_done,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_sticky
);

  typedef enum logic [1:0] {HUNT, SYNC1, LOCKED} state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t     state;
  logic [3:0] idx;
  logic       dir_q;

  logic [6:0] seg;
  logic [3:0] dec_val;
  logic       dec_ok;

  assign seg = {A, B, C, D, E, F, G} ^ {7{SEG_ACTIVE_LOW}};

  always_comb begin
    dec_val = 4'h0;
    dec_ok  = 1'b1;
    case (seg)
      7'b1111110: dec_val = 4'h0;
      7'b0110000: dec_val = 4'h1;
      7'b1101101: dec_val = 4'h2;
      7'b1111001: dec_val = 4'h3;
      7'b0110011: dec_val = 4'h4;
      7'b1011011: dec_val = 4'h5;
      7'b1011111: dec_val = 4'h6;
      7'b1110000: dec_val = 4'h7;
      7'b1111111: dec_val = 4'h8;
      7'b1111011: dec_val = 4'h9;
      7'b1110111: dec_val = 4'hA;
      7'b0011111: dec_val = 4'hB;
      7'b1001110: dec_val = 4'hC;
      7'b0111101: dec_val = 4'hD;
      7'b1001111: dec_val = 4'hE;
      7'b1000111: dec_val = 4'hF;
      default:    dec_ok  = 1'b0;
    endcase
  end

  function automatic logic [3:0] phi_tab(input logic [3:0] i);
    case (i)
      4'd0, 4'd1:                 phi_tab = 4'h1;
      4'd2, 4'd3, 4'd5:           phi_tab = 4'h2;
      4'd4, 4'd7, 4'd9, 4'd11:    phi_tab = 4'h4;
      4'd6, 4'd8, 4'd13:          phi_tab = 4'h6;
      4'd10:                      phi_tab = 4'hA;
      4'd12:                      phi_tab = 4'hC;
      default:                    phi_tab = 4'h8;  // 14, 15
    endcase
  endfunction

  // Descending walks the same table backwards, so both directions share idx.
  logic [3:0] exp_val;
  logic [3:0] start_val;
  logic       dir_chg;
  logic       hit_exp;
  logic       hit_start;
  logic       mis_now;

  assign exp_val   = phi_tab(dir_q ? (4'd15 - idx) : idx);
  assign start_val = dir_q ? 4'h8 : 4'h1;
  assign dir_chg   = (dir != dir_q);
  assign hit_exp   = digit_valid && (digit == exp_val);
  assign hit_start = digit_valid && (digit == start_val);
  assign mis_now   = (state == LOCKED) && !dir_chg && !hit_exp;

  always_ff @(posedge clk_0) begin
    if (R) begin
      digit       <= 4'h0;
      digit_valid <= 1'b0;
      seg_invalid <= 1'b0;
      locked      <= 1'b0;
      mismatch    <= 1'b0;
      period_done <= 1'b0;
      err_cnt     <= '0;
      state       <= HUNT;
      idx         <= 4'd0;
      dir_q       <= 1'b0;
    end else begin
      // stage 1: glyph decode
      digit_valid <= dec_ok;
      seg_invalid <= !dec_ok;
      if (dec_ok) digit <= dec_val;

      // stage 2: sequence tracking on the stage-1 result
      dir_q       <= dir;
      mismatch    <= 1'b0;
      period_done <= 1'b0;
      if (dir_chg) begin
        // new direction invalidates the phase; resync silently
        state  <= HUNT;
        locked <= 1'b0;
        idx    <= 4'd0;
      end else begin
        case (state)
          HUNT: if (hit_start) state <= SYNC1;
          SYNC1: begin
            if (hit_start) begin
              state  <= LOCKED;
              locked <= 1'b1;
              idx    <= 4'd2;
            end else begin
              state <= HUNT;
            end
          end
          LOCKED: begin
            if (hit_exp) begin
              if (idx == 4'd15) begin
                period_done <= 1'b1;
                idx         <= 4'd0;
              end else begin
                idx <= idx + 4'd1;
              end
            end else begin
              mismatch <= 1'b1;
              locked   <= 1'b0;
              state    <= HUNT;
              if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef TOTIENT_CHK_STICKY_EN
  always_ff @(posedge clk_0) begin
    if (R)            fail_sticky <= 1'b0;
    else if (mis_now) fail_sticky <= 1'b1;
  end
`else
  assign fail_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_totient_seg_checker.sv
// Bench for totient_seg_checker: one active-high/ERR_W=8 instance and one
// active-low/ERR_W=2 instance fed the same stream (inverted for the latter),
// both compared every cycle against a sequence model built on a computed
// Euler totient, plus directed literal checks at the key points.
module tb_totient_seg_checker;

  logic clk_0 = 1'b0;
  always #5 clk_0 = ~clk_0;

  logic       R;
  logic       dir;
  logic [6:0] seg;

  logic [3:0] h_digit, l_digit;
  logic       h_dv, l_dv, h_inv, l_inv, h_lk, l_lk, h_mis, l_mis, h_pd, l_pd;
  logic       h_fs, l_fs;
  logic [7:0] h_err;
  logic [1:0] l_err;

  totient_seg_checker #(.SEG_ACTIVE_LOW(1'b0), .ERR_W(8)) dut (
    .clk_0(clk_0), .R(R),
    .A(seg[6]), .B(seg[5]), .C(seg[4]), .D(seg[3]), .E(seg[2]), .F(seg[1]), .G(seg[0]),
    .dir(dir), .digit(h_digit), .digit_valid(h_dv), .seg_invalid(h_inv),
    .locked(h_lk), .mismatch(h_mis), .period_done(h_pd), .err_cnt(h_err),
    .fail_sticky(h_fs)
  );

  totient_seg_checker #(.SEG_ACTIVE_LOW(1'b1), .ERR_W(2)) dut_low (
    .clk_0(clk_0), .R(R),
    .A(~seg[6]), .B(~seg[5]), .C(~seg[4]), .D(~seg[3]), .E(~seg[2]), .F(~seg[1]), .G(~seg[0]),
    .dir(dir), .digit(l_digit), .digit_valid(l_dv), .seg_invalid(l_inv),
    .locked(l_lk), .mismatch(l_mis), .period_done(l_pd), .err_cnt(l_err),
    .fail_sticky(l_fs)
  );

`ifdef TOTIENT_CHK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  localparam logic [6:0] GLY [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  int ASC [16] = '{1, 1, 2, 2, 4, 2, 6, 4, 6, 4, 10, 4, 12, 6, 8, 8};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic int gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b; a = b; b = t;
    end
    return a;
  endfunction

  function automatic int phi(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (gcd(k, n) == 1) c++;
    return c;
  endfunction

  typedef struct {
    int digit; bit dv; bit inv; bit locked; bit mis; bit pd; bit sticky; bit dir;
    int run; int pos; int err;
  } mstate_t;

  function automatic mstate_t step(input mstate_t s, input bit r, input bit d,
                                   input logic [6:0] p, input int errmax);
    mstate_t n;
    int exp_v, start;
    bit found;
    n = s;
    if (r) begin
      n.digit = 0; n.dv = 0; n.inv = 0; n.locked = 0; n.mis = 0; n.pd = 0;
      n.sticky = 0; n.dir = 0; n.run = 0; n.pos = 0; n.err = 0;
      return n;
    end
    n.mis = 0; n.pd = 0;
    start = s.dir ? 8 : 1;
    if (d != s.dir) begin
      n.locked = 0; n.run = 0;
    end else if (s.locked) begin
      // position p in the period holds phi(p+1) ascending, phi(16-p) descending
      exp_v = s.dir ? phi(16 - s.pos) : phi(s.pos + 1);
      if (s.dv && s.digit == exp_v) begin
        if (s.pos == 15) begin n.pd = 1; n.pos = 0; end
        else n.pos = s.pos + 1;
      end else begin
        n.mis = 1; n.locked = 0; n.run = 0; n.sticky = 1;
        if (s.err < errmax) n.err = s.err + 1;
      end
    end else if (s.dv && s.digit == start) begin
      n.run = s.run + 1;
      if (n.run == 2) begin n.locked = 1; n.pos = 2; n.run = 0; end
    end else begin
      n.run = 0;
    end
    n.dir = d;
    found = 0;
    for (int k = 0; k < 16; k++)
      if (!found && GLY[k] == p) begin found = 1; n.digit = k; end
    n.dv  = found;
    n.inv = !found;
    return n;
  endfunction

  mstate_t m0, m1;
  bit chk_en = 0;

  always @(posedge clk_0) begin
    m0 = step(m0, R, dir, seg, 255);
    m1 = step(m1, R, dir, seg, 3);
  end

  task automatic cmp_dut(input string t, input logic [3:0] dg, input logic dv,
                         input logic inv, input logic lk, input logic mis,
                         input logic pd, input logic [31:0] err, input logic fs,
                         input mstate_t m);
    check({t, ".digit_valid"}, dv, m.dv);
    if (m.dv) check({t, ".digit"}, dg, m.digit);
    check({t, ".seg_invalid"}, inv, m.inv);
    check({t, ".locked"}, lk, m.locked);
    check({t, ".mismatch"}, mis, m.mis);
    check({t, ".period_done"}, pd, m.pd);
    check({t, ".err_cnt"}, err, m.err);
    check({t, ".fail_sticky"}, fs, STICKY & m.sticky);
  endtask

  int pd_seen = 0;
  int mis_seen = 0;

  always @(negedge clk_0) begin
    if (chk_en) begin
      cmp_dut("dut", h_digit, h_dv, h_inv, h_lk, h_mis, h_pd, 32'(h_err), h_fs, m0);
      cmp_dut("dut_low", l_digit, l_dv, l_inv, l_lk, l_mis, l_pd, 32'(l_err), l_fs, m1);
      if (h_pd === 1'b1) pd_seen++;
      if (h_mis === 1'b1) mis_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [6:0] p);
    @(negedge clk_0);
    seg = p;
  endtask

  task automatic sendv(input int v);
    send(GLY[v]);
  endtask

  task automatic sendd(input int v, input bit d);
    @(negedge clk_0);
    seg = GLY[v];
    dir = d;
  endtask

  int PD [21] = '{1, 1, 2, 2, 5, 2, 6, 4, 6, 4, 10, 4, 12, 6, 8, 8, 1, 1, 2, 2, 4};

  initial begin
    R = 1'b1; dir = 1'b0; seg = GLY[0];
    chk_en = 1;
    for (int i = 0; i < 16; i++) check("phi table", phi(i + 1), ASC[i]);
    repeat (2) @(negedge clk_0);
    check("reset locked", h_lk, 1'b0);
    check("reset err_cnt", h_err, 0);
    check("reset digit_valid", h_dv, 1'b0);
    R = 1'b0;

    // two clean ascending periods, then the start of a third
    pd_seen = 0; mis_seen = 0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 16; i++) begin
        sendv(ASC[i]);
        if (p == 0 && i == 2) check("asc locked early", h_lk, 1'b0);
        if (p == 0 && i == 3) check("asc locked", h_lk, 1'b1);
        if (p == 1 && i == 0) check("asc pd early", h_pd, 1'b0);
        if (p == 1 && i == 1) check("asc pd", h_pd, 1'b1);
      end
    sendv(1); sendv(1); sendv(2);
    check("asc pd count", pd_seen, 2);
    check("asc mismatch count", mis_seen, 0);
    check("asc err_cnt", h_err, 0);
    check("asc still locked", h_lk, 1'b1);

    // reset while locked
    @(negedge clk_0); R = 1'b1;
    @(negedge clk_0);
    check("midlock rst locked", h_lk, 1'b0);
    check("midlock rst digit", h_digit, 0);
    check("midlock rst dv", h_dv, 1'b0);
    check("midlock rst low locked", l_lk, 1'b0);
    R = 1'b0;

    // relock, corrupt phi(5) with 5, relock on next 1,1
    for (int j = 0; j < 21; j++) begin
      sendv(PD[j]);
      if (j == 3) check("relock after reset", h_lk, 1'b1);
      if (j == 6) begin
        check("corrupt mismatch", h_mis, 1'b1);
        check("corrupt locked", h_lk, 1'b0);
        check("corrupt err_cnt", h_err, 1);
      end
    end
    check("relock after corrupt", h_lk, 1'b1);
    check("err after corrupt", h_err, 1);

    // illegal glyph while locked (expected 2 at this position)
    send(7'b0000001);
    sendv(6);
    check("illegal seg_invalid", h_inv, 1'b1);
    check("illegal digit_valid", h_dv, 1'b0);
    check("illegal digit holds", h_digit, 4);
    sendv(4);
    check("illegal mismatch", h_mis, 1'b1);
    check("illegal err_cnt", h_err, 2);
    check("illegal err_cnt low", l_err, 2);
    sendv(6); sendv(4);

    // descending, then flip dir mid-period
    pd_seen = 0;
    for (int i = 0; i < 20; i++) begin
      sendd(ASC[15 - (i % 16)], 1'b1);
      if (i == 2) check("desc locked early", h_lk, 1'b0);
      if (i == 3) check("desc locked", h_lk, 1'b1);
      if (i == 17) check("desc pd", h_pd, 1'b1);
    end
    check("desc pd count", pd_seen, 1);
    check("desc err_cnt", h_err, 2);
    sendd(4, 1'b0);
    check("dir flip locked before", h_lk, 1'b1);
    sendd(10, 1'b0);
    check("dir flip locked after", h_lk, 1'b0);
    check("dir flip mismatch", h_mis, 1'b0);
    check("dir flip err_cnt", h_err, 2);

    // three more mismatches: 5 total -> 5 on ERR_W=8, saturated 3 on ERR_W=2
    for (int r = 0; r < 3; r++) begin
      sendv(1); sendv(1); sendv(2); sendv(5);
    end
    repeat (3) sendv(0);
    check("sat err_cnt w8", h_err, 5);
    check("sat err_cnt w2", l_err, 3);
    check("sticky dut", h_fs, STICKY);
    check("sticky dut_low", l_fs, STICKY);

    @(negedge clk_0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
